// File: rtl/afe_buff_pkg.sv
// Shared types and constants for the AFE buffer arbiter: output FIFO depth,
// channel index type and the memory-operation encoding used for debug.
package afe_buff_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int AFE_NCH    = 4;

  typedef logic [$clog2(AFE_NCH)-1:0] afe_ch_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } mem_op_e;

endpackage

// File: rtl/afe_buff_arbiter_if.sv
// Sample-SRAM port and uDMA output stream of the AFE buffer arbiter,
// plus the registered last-operation debug signal.
interface afe_buff_arbiter_if
  import afe_buff_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int CH_W   = 2
) ();

  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  mem_op_e           last_op;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output out_valid, out_data, out_ch,
    input  out_ready,
    output last_op
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  out_valid, out_data, out_ch,
    output out_ready,
    input  last_op
  );

endinterface

// File: rtl/afe_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves to winner+1 when advance is enabled.
module afe_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (adv_i && any_o) begin
      ptr_q <= (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/afe_buff_arbiter.sv
// Single-port sample-SRAM arbiter: per-channel sample holding registers,
// write-priority round-robin access, credit-gated read-out into a 2-deep FIFO.
// Optional per-channel dropped-sample counters: AFE_BUFF_ARB_DROP_CNT_EN.
module afe_buff_arbiter
  import afe_buff_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCH-1:0]               smpl_valid_i,
  input  logic [NCH-1:0][DWIDTH-1:0]   smpl_data_i,
  input  logic [NCH-1:0]               ch_en_i,
  input  logic [NCH-1:0][AWIDTH-1:0]   wr_addr_i,
  input  logic [NCH-1:0][AWIDTH-1:0]   rd_addr_i,
  input  logic [NCH-1:0]               rd_valid_i,
  output logic [NCH-1:0]               wr_ready_o,
  output logic [NCH-1:0]               rd_ready_o,
  afe_buff_arbiter_if.master           bus,
  output logic [NCH-1:0]               ovf_o,
  input  logic [NCH-1:0]               ovf_clr_i,
  output logic [NCH-1:0][CNT_W-1:0]    drop_cnt_o
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DWIDTH-1:0] data;
  } fifo_ent_t;

  // Sample holding registers
  logic [NCH-1:0]             hold_vld_q;
  logic [NCH-1:0][DWIDTH-1:0] hold_data_q;
  logic [NCH-1:0]             hold_load;
  logic [NCH-1:0]             drop;
  logic [NCH-1:0]             ovf_q;

  // Arbitration
  logic [NCH-1:0]  wr_req, rd_req;
  logic [NCH-1:0]  wr_gnt, rd_gnt;
  logic [CH_W-1:0] wr_idx, rd_idx;
  logic            wr_any, rd_any;
  logic            credit_ok;

  // Read return path
  logic            inflight_q;
  logic [CH_W-1:0] inflight_ch_q;
  fifo_ent_t       fifo_q [FIFO_DEPTH];
  logic [1:0]      fifo_cnt_q;
  logic            out_valid;
  logic            push, pop;

  mem_op_e         op;
  mem_op_e         last_op_q;

  // Requests are masked during reset so no grant leaks out of a reset cycle.
  assign wr_req = rst_ni ? (hold_vld_q & ch_en_i) : '0;
  assign rd_req = (rst_ni && !wr_any && credit_ok) ? (rd_valid_i & ch_en_i) : '0;

  afe_rr_arbiter #(.N(NCH)) u_wr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (wr_req),
    .adv_i     (1'b1),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx),
    .any_o     (wr_any)
  );

  afe_rr_arbiter #(.N(NCH)) u_rd_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (rd_req),
    .adv_i     (1'b1),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx),
    .any_o     (rd_any)
  );

  assign wr_ready_o = wr_gnt;
  assign rd_ready_o = rd_gnt;

  // A granted channel may reload in the same cycle; otherwise a busy holder drops.
  assign hold_load = ch_en_i & smpl_valid_i & (~hold_vld_q | wr_gnt);
  assign drop      = ch_en_i & smpl_valid_i & hold_vld_q & ~wr_gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_vld_q <= '0;
      ovf_q      <= '0;
    end else begin
      hold_vld_q <= ch_en_i & (hold_load | (hold_vld_q & ~wr_gnt));
      ovf_q      <= drop | (ovf_q & ~ovf_clr_i);
    end
  end

  // NOTE: data registers are not reset; their valid flags gate every use.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (hold_load[i]) hold_data_q[i] <= smpl_data_i[i];
    end
  end

  assign ovf_o = ovf_q;

  // Memory port: writes always win over reads.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    op            = IDLE;
    if (wr_any) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = wr_addr_i[wr_idx];
      bus.mem_wdata = hold_data_q[wr_idx];
      op            = WR;
    end else if (rd_any) begin
      bus.mem_req   = 1'b1;
      bus.mem_addr  = rd_addr_i[rd_idx];
      op            = RD;
    end
  end

  // Credit counts the slot freed by a pop in this same cycle, sustaining 1 word/cycle.
  always_comb begin
    credit_ok = (int'(fifo_cnt_q) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  end

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign push      = inflight_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_ch_q <= '0;
      fifo_cnt_q    <= '0;
      last_op_q     <= IDLE;
    end else begin
      inflight_q    <= rd_any;
      inflight_ch_q <= rd_idx;
      last_op_q     <= op;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Head always sits in slot 0; a pop shifts slot 1 forward.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      if (push && fifo_cnt_q == 2'd1) fifo_q[0] <= '{ch: inflight_ch_q, data: bus.mem_rdata};
      else                            fifo_q[0] <= fifo_q[1];
      if (push && fifo_cnt_q == 2'd2) fifo_q[1] <= '{ch: inflight_ch_q, data: bus.mem_rdata};
    end else if (push) begin
      if (fifo_cnt_q == 2'd0) fifo_q[0] <= '{ch: inflight_ch_q, data: bus.mem_rdata};
      else                    fifo_q[1] <= '{ch: inflight_ch_q, data: bus.mem_rdata};
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? fifo_q[0].data : '0;
  assign bus.out_ch    = out_valid ? fifo_q[0].ch : '0;
  assign bus.last_op   = last_op_q;

`ifdef AFE_BUFF_ARB_DROP_CNT_EN
  logic [NCH-1:0][CNT_W-1:0] drop_cnt_q;

  // A drop in the clear cycle restarts the count at one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (drop[i]) begin
          if (ovf_clr_i[i])        drop_cnt_q[i] <= CNT_W'(1);
          else if (!(&drop_cnt_q[i])) drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
        end else if (ovf_clr_i[i]) begin
          drop_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_afe_buff_arbiter.sv
// Directed bench for afe_buff_arbiter with a registered-read SRAM model.
module tb_afe_buff_arbiter;
  import afe_buff_pkg::*;

`ifdef AFE_BUFF_ARB_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [3:0]       smpl_valid, ch_en, rd_valid, ovf_clr;
  logic [3:0]       wr_ready, rd_ready, ovf;
  logic [3:0][31:0] smpl_data;
  logic [3:0][9:0]  wr_addr, rd_addr;
  logic [3:0][15:0] drop_cnt;
  logic [31:0]      sram [1024];

  int n_chk  = 0;
  int n_pass = 0;

  afe_buff_arbiter_if #(.AWIDTH(10), .DWIDTH(32), .CH_W(2)) bus ();

  afe_buff_arbiter #(.NCH(4), .AWIDTH(10), .DWIDTH(32), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .smpl_valid_i (smpl_valid),
    .smpl_data_i  (smpl_data),
    .ch_en_i      (ch_en),
    .wr_addr_i    (wr_addr),
    .rd_addr_i    (rd_addr),
    .rd_valid_i   (rd_valid),
    .wr_ready_o   (wr_ready),
    .rd_ready_o   (rd_ready),
    .bus          (bus),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (bus.mem_req && bus.mem_we)  sram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_req && !bus.mem_we) bus.mem_rdata <= sram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    smpl_valid    = '0;
    rd_valid      = '0;
    ovf_clr       = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    bus.mem_rdata = '0;
    ch_en     = 4'hF;
    smpl_data = '0;
    wr_addr   = '0;
    rd_addr   = '0;
    rd_valid  = 4'b1111;
    do_reset();
    rd_valid = '0;
    #1;
    check("rst_mem_req",   32'(bus.mem_req), 0);
    check("rst_mem_we",    32'(bus.mem_we), 0);
    check("rst_mem_addr",  32'(bus.mem_addr), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_wr_ready",  32'(wr_ready), 0);
    check("rst_rd_ready",  32'(rd_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_out_ch",    32'(bus.out_ch), 0);
    check("rst_ovf",       32'(ovf), 0);
    check("rst_drop_cnt",  32'(|drop_cnt), 0);

    // Single-channel write then read-back
    smpl_valid   = 4'b0001;
    smpl_data[0] = 32'hA5A5_0001;
    wr_addr[0]   = 10'h010;
    #1;
    check("t1_no_req_yet", 32'(bus.mem_req), 0);
    tick();
    smpl_valid = '0;
    #1;
    check("t1_wr_we",    32'(bus.mem_we), 1);
    check("t1_wr_addr",  32'(bus.mem_addr), 'h010);
    check("t1_wr_data",  bus.mem_wdata, 32'hA5A5_0001);
    check("t1_wr_ready", 32'(wr_ready), 'b0001);
    tick();
    rd_valid   = 4'b0001;
    rd_addr[0] = 10'h010;
    #1;
    check("t1_last_op_wr", 32'(bus.last_op), 32'(WR));
    check("t1_rd_ready",   32'(rd_ready), 'b0001);
    check("t1_rd_req",     32'(bus.mem_req), 1);
    check("t1_rd_we",      32'(bus.mem_we), 0);
    check("t1_rd_addr",    32'(bus.mem_addr), 'h010);
    tick();
    rd_valid = '0;
    #1;
    check("t1_last_op_rd",  32'(bus.last_op), 32'(RD));
    check("t1_not_yet_vld", 32'(bus.out_valid), 0);
    tick();
    #1;
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_data",  bus.out_data, 32'hA5A5_0001);
    check("t1_out_ch",    32'(bus.out_ch), 0);
    tick();
    #1;
    check("t1_out_stable", bus.out_data, 32'hA5A5_0001);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("t1_popped", 32'(bus.out_valid), 0);

    // Four simultaneous samples, second burst reloads ch3 in its grant cycle
    do_reset();
    smpl_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      smpl_data[i] = 32'h100 + i;
      wr_addr[i]   = 10'(32'h20 + i);
    end
    tick();
    smpl_valid = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        smpl_valid = 4'hF;
        for (int i = 0; i < 4; i++) smpl_data[i] = 32'h200 + i;
      end
      #1;
      check($sformatf("t2_b1_gnt%0d", k),  32'(wr_ready), 32'd1 << k);
      check($sformatf("t2_b1_addr%0d", k), 32'(bus.mem_addr), 32'h20 + k);
      check($sformatf("t2_b1_data%0d", k), bus.mem_wdata, 32'h100 + k);
      tick();
      smpl_valid = '0;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_b2_gnt%0d", k),  32'(wr_ready), 32'd1 << k);
      check($sformatf("t2_b2_data%0d", k), bus.mem_wdata, 32'h200 + k);
      check($sformatf("t2_b2_ovf%0d", k),  32'(ovf), 0);
      tick();
    end
    #1;
    check("t2_idle_gnt",  32'(wr_ready), 0);
    check("t2_idle_req",  32'(bus.mem_req), 0);
    check("t2_idle_addr", 32'(bus.mem_addr), 0);

    // Drop on channel 2 while channels 0 and 1 are ahead of it
    do_reset();
    smpl_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      smpl_data[i] = 32'h300 + i;
      wr_addr[i]   = 10'(32'h40 + i);
    end
    tick();
    smpl_valid   = 4'b0100;
    smpl_data[2] = 32'h3FF;
    #1;
    check("t3_gnt_ch0", 32'(wr_ready), 'b0001);
    check("t3_ovf_pre", 32'(ovf), 0);
    tick();
    smpl_valid = '0;
    #1;
    check("t3_ovf_set",   32'(ovf), 'b0100);
    check("t3_drop_cnt2", 32'(drop_cnt[2]), EXP_DROP);
    check("t3_gnt_ch1",   32'(wr_ready), 'b0010);
    tick();
    #1;
    check("t3_gnt_ch2",  32'(wr_ready), 'b0100);
    check("t3_kept_old", bus.mem_wdata, 32'h302);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = '0;
    #1;
    check("t3_ovf_clr",  32'(ovf), 0);
    check("t3_cnt_clr",  32'(drop_cnt[2]), 0);
    check("t3_idle_req", 32'(bus.mem_req), 0);

    // Reads on ch1/ch3 with a stalled consumer: credit stops at two
    do_reset();
    rd_valid   = 4'b1010;
    rd_addr[1] = 10'h021;
    rd_addr[3] = 10'h023;
    #1;
    check("t4_rd0",      32'(rd_ready), 'b0010);
    check("t4_rd0_addr", 32'(bus.mem_addr), 'h021);
    tick();
    #1;
    check("t4_rd1",      32'(rd_ready), 'b1000);
    check("t4_rd1_addr", 32'(bus.mem_addr), 'h023);
    tick();
    #1;
    check("t4_rd2_none",  32'(rd_ready), 0);
    check("t4_rd2_req",   32'(bus.mem_req), 0);
    check("t4_head_vld",  32'(bus.out_valid), 1);
    check("t4_head_data", bus.out_data, 32'h201);
    check("t4_head_ch",   32'(bus.out_ch), 1);
    tick();
    #1;
    check("t4_rd3_none",  32'(rd_ready), 0);
    check("t4_head_hold", bus.out_data, 32'h201);
    bus.out_ready = 1'b1;
    #1;
    check("t4_resume_ch1", 32'(rd_ready), 'b0010);
    tick();
    #1;
    check("t4_head2_ch",   32'(bus.out_ch), 3);
    check("t4_head2_data", bus.out_data, 32'h203);
    check("t4_next_ch3",   32'(rd_ready), 'b1000);
    rd_valid = '0;
    tick();
    #1;
    check("t4_head3_ch",   32'(bus.out_ch), 1);
    check("t4_head3_data", bus.out_data, 32'h201);
    tick();
    tick();
    tick();
    #1;
    check("t4_drained", 32'(bus.out_valid), 0);

    // Continuous writes on ch0 hold off a pending read on ch1
    smpl_valid   = 4'b0001;
    smpl_data[0] = 32'h500;
    wr_addr[0]   = 10'h050;
    tick();
    for (int k = 0; k < 4; k++) begin
      rd_valid     = 4'b0010;
      smpl_valid   = (k < 3) ? 4'b0001 : 4'b0000;
      smpl_data[0] = 32'h501 + k;
      #1;
      check($sformatf("t5_no_rd%0d", k), 32'(rd_ready), 0);
      check($sformatf("t5_wr%0d", k),    32'(wr_ready), 'b0001);
      check($sformatf("t5_data%0d", k),  bus.mem_wdata, 32'h500 + k);
      tick();
    end
    smpl_valid = '0;
    #1;
    check("t5_idle_wr", 32'(wr_ready), 0);
    check("t5_idle_rd", 32'(rd_ready), 'b0010);
    tick();

    // Reset in the cycle after a read grant discards the returning word
    rst_ni   = 1'b0;
    rd_valid = '0;
    #1;
    check("t6_rst_rd_ready", 32'(rd_ready), 0);
    check("t6_rst_mem_req",  32'(bus.mem_req), 0);
    tick();
    rst_ni = 1'b1;
    #1;
    check("t6_out_valid0", 32'(bus.out_valid), 0);
    check("t6_ovf",        32'(ovf), 0);
    tick();
    #1;
    check("t6_out_valid1", 32'(bus.out_valid), 0);
    check("t6_out_data",   bus.out_data, 0);
    smpl_valid   = 4'b0011;
    smpl_data[0] = 32'h600;
    smpl_data[1] = 32'h601;
    tick();
    smpl_valid = '0;
    #1;
    check("t6_first_wr_ch0", 32'(wr_ready), 'b0001);
    tick();
    #1;
    check("t6_then_ch1", 32'(wr_ready), 'b0010);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
